// File: rtl/guess_link_pkg.sv
// Shared definitions for the two-player game link.
// Holds the frame header, the frame length, the message type enum, the
// frame-sequencer and byte-serialiser state encodings, and the helper
// that builds each frame byte from a latched payload.
package guess_link_pkg;

   localparam logic [7:0] FRAME_HDR   = 8'hA5;
   localparam int         FRAME_BYTES = 4;

   typedef enum logic [2:0] {
      MSG_SELECT = 3'd0,
      MSG_BOARD  = 3'd1,
      MSG_GUESS  = 3'd2
   } msg_t;

   typedef logic [1:0] frame_state_t;
   localparam frame_state_t FS_IDLE   = 2'd0;
   localparam frame_state_t FS_BYTE   = 2'd1;
   localparam frame_state_t FS_FINISH = 2'd2;

   typedef logic [1:0] uart_state_t;
   localparam uart_state_t US_IDLE  = 2'd0;
   localparam uart_state_t US_START = 2'd1;
   localparam uart_state_t US_DATA  = 2'd2;
   localparam uart_state_t US_STOP  = 2'd3;

   // Byte idx of the frame: header, {type, mask[8], person}, mask[7:0], xor checksum.
   function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                             input logic [2:0] msg,
                                             input logic [3:0] person,
                                             input logic [8:0] mask);
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] res;
      b1 = {msg, mask[8], person};
      b2 = mask[7:0];
      case (idx)
         2'd0:    res = FRAME_HDR;
         2'd1:    res = b1;
         2'd2:    res = b2;
         default: res = FRAME_HDR ^ b1 ^ b2;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte-level UART 8N1 serialiser, LSB first, idle high.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load data and begin a start bit next cycle (honoured when ready)
//   data        byte to send, captured on the accepted start cycle
//   tx          serial line
//   ready       idle, or in the last cycle of a stop bit so a following
//               byte can begin with no idle gap
//
// state    | meaning
// US_IDLE  | line idle high, waiting for start
// US_START | start bit (0)
// US_DATA  | data bits 0..7
// US_STOP  | stop bit (1)
module uart_tx_byte
   import guess_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 564
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          tx_q, tx_d;
   logic          bit_end;

   assign bit_end = (cnt_q == CNT_LAST);
   assign ready   = (state_q == US_IDLE) || ((state_q == US_STOP) && bit_end);
   assign tx      = tx_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      tx_d    = tx_q;
      if (start && ready) begin
         state_d = US_START;
         cnt_d   = '0;
         data_d  = data;
         tx_d    = 1'b0;
      end else begin
         case (state_q)
            US_START: begin
               if (bit_end) begin
                  state_d = US_DATA;
                  cnt_d   = '0;
                  bit_d   = 3'd0;
                  tx_d    = data_q[0];
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            US_DATA: begin
               if (bit_end) begin
                  cnt_d = '0;
                  if (bit_q == 3'd7) begin
                     state_d = US_STOP;
                     tx_d    = 1'b1;
                  end else begin
                     bit_d = bit_q + 3'd1;
                     tx_d  = data_q[bit_q + 3'd1];
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            US_STOP: begin
               if (bit_end) begin
                  state_d = US_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = US_IDLE;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= US_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         data_q  <= 8'h00;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/guess_frame_tx.sv
// Transmit end of the game link: packs msg_type, person and the 9-card flip
// mask into a 4-byte frame (A5, {type,mask[8],person}, mask[7:0], xor) and
// sends it as UART 8N1 through uart_tx_byte.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   send        one-cycle frame request
//   msg_type    message type, sent unchecked
//   person      selected person index
//   mask        card flip mask
//   busy        frame active or pending
//   done        one-cycle pulse after the last stop bit of a frame
//   tx          UART line, idle high
//
// state     | meaning
// FS_IDLE   | no frame, waiting for send
// FS_BYTE   | a frame byte is on the line; byte_idx_q selects which
// FS_FINISH | one cycle after B3 stop bit: done pulse, restart if pending
module guess_frame_tx
   import guess_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 564
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       send,
   input  logic [2:0] msg_type,
   input  logic [3:0] person,
   input  logic [8:0] mask,
   output logic       busy,
   output logic       done,
   output logic       tx
);

   localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

   frame_state_t state_q, state_d;
   logic [1:0]   byte_idx_q, byte_idx_d;
   logic         pend_q, pend_d;
   logic [2:0]   msg_q, msg_d, sh_msg_q, sh_msg_d;
   logic [3:0]   person_q, person_d, sh_person_q, sh_person_d;
   logic [8:0]   mask_q, mask_d, sh_mask_q, sh_mask_d;
   logic         byte_start;
   logic [7:0]   byte_data;
   logic         byte_ready;

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .clk   (clk),
      .rst_n (rst_n),
      .start (byte_start),
      .data  (byte_data),
      .tx    (tx),
      .ready (byte_ready)
   );

   assign done = (state_q == FS_FINISH);
   assign busy = (state_q == FS_BYTE) || ((state_q == FS_FINISH) && pend_q);

   always_comb begin
      state_d     = state_q;
      byte_idx_d  = byte_idx_q;
      pend_d      = pend_q;
      msg_d       = msg_q;
      person_d    = person_q;
      mask_d      = mask_q;
      sh_msg_d    = sh_msg_q;
      sh_person_d = sh_person_q;
      sh_mask_d   = sh_mask_q;
      byte_start  = 1'b0;
      byte_data   = FRAME_HDR;
      case (state_q)
         FS_IDLE: begin
            if (send) begin
               msg_d      = msg_type;
               person_d   = person;
               mask_d     = mask;
               byte_idx_d = 2'd0;
               byte_start = 1'b1;
               state_d    = FS_BYTE;
            end
         end
         FS_BYTE: begin
            if (send) begin
               pend_d      = 1'b1;
               sh_msg_d    = msg_type;
               sh_person_d = person;
               sh_mask_d   = mask;
            end
            // ready here means the current stop bit ends this cycle
            if (byte_ready) begin
               if (byte_idx_q == LAST_BYTE) begin
                  state_d = FS_FINISH;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  byte_start = 1'b1;
                  byte_data  = frame_byte(byte_idx_q + 2'd1, msg_q, person_q, mask_q);
               end
            end
         end
         FS_FINISH: begin
            pend_d = 1'b0;
            if (send || pend_q) begin
               // a request arriving now is newer than the shadow copy
               if (send) begin
                  msg_d    = msg_type;
                  person_d = person;
                  mask_d   = mask;
               end else begin
                  msg_d    = sh_msg_q;
                  person_d = sh_person_q;
                  mask_d   = sh_mask_q;
               end
               byte_idx_d = 2'd0;
               byte_start = 1'b1;
               state_d    = FS_BYTE;
            end else begin
               state_d = FS_IDLE;
            end
         end
         default: state_d = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FS_IDLE;
         byte_idx_q  <= 2'd0;
         pend_q      <= 1'b0;
         msg_q       <= 3'd0;
         person_q    <= 4'd0;
         mask_q      <= 9'd0;
         sh_msg_q    <= 3'd0;
         sh_person_q <= 4'd0;
         sh_mask_q   <= 9'd0;
      end else begin
         state_q     <= state_d;
         byte_idx_q  <= byte_idx_d;
         pend_q      <= pend_d;
         msg_q       <= msg_d;
         person_q    <= person_d;
         mask_q      <= mask_d;
         sh_msg_q    <= sh_msg_d;
         sh_person_q <= sh_person_d;
         sh_mask_q   <= sh_mask_d;
      end
   end

endmodule

// File: tb/tb_guess_frame_tx.sv
// Bench for guess_frame_tx with a short bit period. A line monitor decodes
// the UART stream into bytes; expected frames come from a table of
// hand-computed constants and from a payload-to-bytes model.
module tb_guess_frame_tx;

   localparam int CPB = 4;
   localparam int FRAME_CYC = 40 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       send = 1'b0;
   logic [2:0] msg_type = 3'd0;
   logic [3:0] person = 4'd0;
   logic [8:0] mask = 9'd0;
   logic       busy, done, tx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   int         fall_q[$];

   guess_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .send     (send),
      .msg_type (msg_type),
      .person   (person),
      .mask     (mask),
      .busy     (busy),
      .done     (done),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Frame bytes straight from the frame layout rules.
   function automatic logic [31:0] model(input logic [2:0] m, input logic [3:0] p,
                                         input logic [8:0] k);
      logic [7:0] b0, b1, b2;
      b0 = 8'hA5;
      b1 = {m, k[8], p};
      b2 = k[7:0];
      return {b0, b1, b2, b0 ^ b1 ^ b2};
   endfunction

   // UART line monitor: sample each bit in its middle, check framing bits.
   initial begin
      bit         mon_on = 1'b0;
      int         mon_cnt = 0;
      logic [7:0] mon_byte = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_on = 1'b0;
         end else if (!mon_on) begin
            if (tx === 1'b0) begin
               mon_on  = 1'b1;
               mon_cnt = 0;
               fall_q.push_back(cyc);
            end
         end else begin
            mon_cnt = mon_cnt + 1;
            if ((mon_cnt % CPB) == (CPB / 2)) begin
               int j;
               j = mon_cnt / CPB;
               if (j == 0) begin
                  chk("start_bit", 32'(tx), 32'd0);
               end else if (j <= 8) begin
                  mon_byte[j-1] = tx;
               end else begin
                  chk("stop_bit", 32'(tx), 32'd1);
                  rx_q.push_back(mon_byte);
                  mon_on = 1'b0;
               end
            end
         end
      end
   end

   task automatic do_send(input logic [2:0] m, input logic [3:0] p, input logic [8:0] k);
      msg_type = m;
      person   = p;
      mask     = k;
      send     = 1'b1;
      @(negedge clk);
      send     = 1'b0;
   endtask

   task automatic wait_done(input bit wiggle, output bit got);
      got = 1'b0;
      for (int i = 0; i < 4 * FRAME_CYC; i++) begin
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (wiggle) begin
            msg_type = 3'($urandom_range(7));
            person   = 4'($urandom_range(15));
            mask     = 9'($urandom_range(511));
         end
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input string nm, input logic [31:0] exp);
      int prev;
      if (rx_q.size() < 4 || fall_q.size() < 4) begin
         chk({nm, "_nbytes"}, 32'(rx_q.size()), 32'd4);
         return;
      end
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         int f;
         b = rx_q.pop_front();
         f = fall_q.pop_front();
         chk($sformatf("%s_b%0d", nm, i), 32'(b), 32'(exp[31-8*i -: 8]));
         if (i > 0) chk($sformatf("%s_gap%0d", nm, i), 32'(f - prev), 32'(10 * CPB));
         prev = f;
      end
   endtask

   task automatic run_frame(input string nm, input logic [2:0] m, input logic [3:0] p,
                            input logic [8:0] k, input logic [31:0] exp, input bit wiggle);
      int t0;
      bit got;
      rx_q.delete();
      fall_q.delete();
      chk({nm, "_pre_tx"}, 32'(tx), 32'd1);
      do_send(m, p, k);
      t0 = cyc;
      chk({nm, "_fall"}, 32'(tx), 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      wait_done(wiggle, got);
      chk({nm, "_done_seen"}, 32'(got), 32'd1);
      chk({nm, "_done_time"}, 32'(cyc - t0), 32'(FRAME_CYC));
      chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({nm, "_done_width"}, 32'(done), 32'd0);
      chk({nm, "_tx_idle"}, 32'(tx), 32'd1);
      check_frame(nm, exp);
   endtask

   typedef struct {
      logic [2:0]  m;
      logic [3:0]  p;
      logic [8:0]  k;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      bit got;
      bit ok;
      int t0;

      vecs[0] = '{m: 3'd1, p: 4'd5,  k: 9'h1FF, exp: 32'hA535FF6F};
      vecs[1] = '{m: 3'd0, p: 4'd0,  k: 9'h000, exp: 32'hA50000A5};
      vecs[2] = '{m: 3'd2, p: 4'd9,  k: 9'h0AA, exp: 32'hA549AA46};
      vecs[3] = '{m: 3'd7, p: 4'd15, k: 9'h100, exp: 32'hA5FF005A};
      vecs[4] = '{m: 3'd3, p: 4'd1,  k: 9'h155, exp: 32'hA5715581};

      // reset held: outputs idle whatever send does
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         send = i[0];
      end
      send = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      chk("idle_after_rst", 32'(ok), 32'd1);

      for (int i = 0; i < 5; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].m, vecs[i].p, vecs[i].k, vecs[i].exp, 1'b0);

      // random payloads, inputs changing every cycle while the frame is out
      for (int i = 0; i < 6; i++) begin
         logic [2:0] m;
         logic [3:0] p;
         logic [8:0] k;
         m = 3'($urandom_range(7));
         p = 4'($urandom_range(15));
         k = 9'($urandom_range(511));
         run_frame($sformatf("rnd%0d", i), m, p, k, model(m, p, k), 1'b1);
         repeat (2) @(negedge clk);
      end

      // pending slot: two requests during a frame, the last one wins
      rx_q.delete();
      fall_q.delete();
      do_send(3'd0, 4'd2, 9'h003);
      t0 = cyc;
      repeat (28) @(negedge clk);
      do_send(3'd2, 4'd7, 9'h010);
      do_send(3'd1, 4'd9, 9'h1F0);
      msg_type = 3'd0;
      person   = 4'd0;
      mask     = 9'd0;
      wait_done(1'b0, got);
      chk("pend_done_seen", 32'(got), 32'd1);
      chk("pend_done_time", 32'(cyc - t0), 32'(FRAME_CYC));
      chk("pend_busy_at_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("pend_done_width", 32'(done), 32'd0);
      chk("pend_restart_tx", 32'(tx), 32'd0);
      chk("pend_restart_busy", 32'(busy), 32'd1);
      wait_done(1'b0, got);
      chk("pend_done2_seen", 32'(got), 32'd1);
      chk("pend_busy_end", 32'(busy), 32'd0);
      repeat (200) @(negedge clk);
      chk("pend_nbytes", 32'(rx_q.size()), 32'd8);
      check_frame("pend_f1", model(3'd0, 4'd2, 9'h003));
      check_frame("pend_f2", model(3'd1, 4'd9, 9'h1F0));

      // request landing in the done cycle chains a new frame
      rx_q.delete();
      fall_q.delete();
      do_send(3'd1, 4'd3, 9'h0F0);
      wait_done(1'b0, got);
      chk("fin_done_seen", 32'(got), 32'd1);
      do_send(3'd2, 4'd4, 9'h101);
      chk("fin_restart_tx", 32'(tx), 32'd0);
      chk("fin_restart_busy", 32'(busy), 32'd1);
      wait_done(1'b0, got);
      chk("fin_done2_seen", 32'(got), 32'd1);
      chk("fin_busy_end", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check_frame("fin_f1", model(3'd1, 4'd3, 9'h0F0));
      check_frame("fin_f2", model(3'd2, 4'd4, 9'h101));

      // reset in the middle of B2's data bits
      rx_q.delete();
      fall_q.delete();
      do_send(3'd1, 4'd6, 9'h1A5);
      repeat (89) @(negedge clk);
      chk("mid_pre_tx", 32'(tx), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_frame("after_rst", 3'd2, 4'd8, 9'h0C3, model(3'd2, 4'd8, 9'h0C3), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/guess_frame_tx.md
Name: guess_frame_tx

Overview:
- Transmit end of the two-player game link.
- Packs the local player's chosen person, the 9-card flip mask and a message type into a fixed 4-byte frame.
- Serialises the frame as UART 8N1 (LSB first) on a single tx line to the opponent board.
- Sits beside the image/selection logic and is driven from the game state machine. The opponent's receiver decodes the same frame format.

Parameters:
- CLKS_PER_BIT, 564, clk cycles per UART bit (65 MHz / 115200); legal range ≥ 2.
- FRAME_BYTES, 4, bytes per frame; fixed by the package constant, not to be overridden.

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- send  in  1  one-cycle request to transmit a frame
- msg_type  in  3  message type (package enum)
- person  in  4  selected person index, 0 = none, 1..9 = card
- mask  in  9  card flip mask, bit k = card k+1 flipped
- busy  out  1  high while a frame is active or pending
- done  out  1  one-cycle pulse when a frame's last stop bit completes
- tx  out  1  UART line, idle high

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, done=0. FSM goes to IDLE; pending flag and all payload registers clear. Reset mid-frame aborts immediately; tx returns high with no partial stop bit.
- Frame layout, in send order:
  - B0 = 8'hA5 (header)
  - B1 = {msg_type[2:0], mask[8], person[3:0]}
  - B2 = mask[7:0]
  - B3 = B0 ^ B1 ^ B2
- Payload is latched on the accepted send cycle. Later input changes do not affect the frame in flight.
- FSM: IDLE -> START -> DATA -> STOP -> (NEXT_BYTE -> START | FINISH -> IDLE / START).
- IDLE: on send=1, latch payload, busy=1 next cycle, enter START. tx falls on cycle n+1 after send at cycle n.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits LSB first, each CLKS_PER_BIT cycles. A 3-bit bit index counts 0..7.
- STOP: tx=1 for CLKS_PER_BIT cycles.
- Between bytes there is no idle gap; the next start bit follows the stop bit directly.
- Byte index counts 0..3. After B3's stop bit:
  - done pulses for exactly one cycle.
  - If no request is pending, busy drops in that same cycle and the FSM returns to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary. Each bit lasts exactly CLKS_PER_BIT cycles, so the frame totals 40*CLKS_PER_BIT cycles.
- send while busy: one-deep pending slot.
  - The pending flag sets and the payload is captured in a shadow register; the last request wins.
  - At frame end with pending set: done pulses, busy stays 1, pending clears, the shadow loads, and START begins the next cycle.
  - The in-flight frame is never modified.
- send in the same cycle as the FINISH of a frame: treated as pending, same as above.
- Checksum is computed from the latched payload at frame start, never from live inputs.
- Reserved msg_type values (3..7) are transmitted unchanged; this block does no validation.

Decomposition:
- Package guess_link_pkg holds:
  - FRAME_HDR = 8'hA5
  - FRAME_BYTES = 4
  - typedef enum logic [2:0] msg_t: MSG_SELECT=0, MSG_BOARD=1, MSG_GUESS=2
  - FSM state typedef
- Sub-module uart_tx_byte: byte-level 8N1 serialiser containing the baud counter and bit index.
  - Interface: start, data[7:0], tx, ready.
  - guess_frame_tx keeps the frame sequencer, pending slot and checksum.

Test Plan (CLKS_PER_BIT=4):
- Reset: hold rst_n=0, toggle send -> tx=1, busy=0, done=0 throughout. Release; idle 100 cycles -> tx stays 1.
- Basic frame: send with msg_type=1, person=5, mask=9'h1FF.
  - tx falls 1 cycle later.
  - Decoded bytes A5, 35, FF, 6F.
  - done one cycle at 160 cycles after tx fall; busy=0 same cycle.
- Zero payload: msg_type=0, person=0, mask=0 -> bytes A5, 00, 00, A5. Each byte has a start bit=0 and a stop bit=1, and no gap between bytes.
- Pending: send (person=2) then, 30 cycles later, two sends (person=7, then person=9).
  - First frame is unchanged.
  - done pulses; busy stays 1.
  - Second frame follows immediately with B1 low nibble = 9.
  - Exactly two frames are sent.
- Reset mid-frame: assert rst_n during DATA of B2 -> tx=1 immediately, busy=0. After release, a new send produces a complete, correct frame.
- Input change during frame: alter person and mask every cycle while busy → transmitted bytes match the values latched at the send cycle.
